// File: rtl/icu_seq_pkg.sv
// Shared definitions for the icu_seq instruction-sequencing unit.
// Holds the 4-bit opcode encoding of the MC14500B-style instruction set.
package icu_seq_pkg;

    typedef enum logic [3:0] {
        NOPO = 4'h0,
        LD   = 4'h1,
        LDC  = 4'h2,
        AND  = 4'h3,
        ANDC = 4'h4,
        OR   = 4'h5,
        ORC  = 4'h6,
        XNOR = 4'h7,
        STO  = 4'h8,
        STOC = 4'h9,
        IEN  = 4'hA,
        OEN  = 4'hB,
        JMP  = 4'hC,
        RTN  = 4'hD,
        SKZ  = 4'hE,
        NOPF = 4'hF
    } instruction_t;

endpackage

// File: rtl/icu_seq_stack.sv
// icu_stack: synchronous LIFO holding JMP return addresses.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push, pop     push din / pop top entry (ignored when full / empty)
//   din           address to push
//   dout          current top-of-stack entry (valid while not empty)
//   full, empty   occupancy status
//   level         number of stored entries
module icu_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  logic [ADDR_W-1:0]                din,
    output logic [ADDR_W-1:0]                dout,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(STACK_DEPTH+1)-1:0] level
);

    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [LVL_W-1:0]  level_reg;
    logic [LVL_W-1:0]  level_next;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  top_ptr;
    logic              do_push;
    logic              do_pop;

    // The write slot is the current level; the top entry sits one below.
    // Modular subtraction in PTR_W bits is exact because level-1 < 2^PTR_W.
    assign wr_ptr  = level_reg[PTR_W-1:0];
    assign top_ptr = wr_ptr - PTR_W'(1);

    assign full    = (level_reg == LVL_W'(STACK_DEPTH));
    assign empty   = (level_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[top_ptr];
    assign level   = level_reg;

    // Each entry is its own register so the top is readable in the same
    // cycle that RTN consumes it.
    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem[gi] <= '0;
                end else if (do_push && (wr_ptr == PTR_W'(gi))) begin
                    mem[gi] <= din;
                end
            end
        end
    endgenerate

    always_comb begin
        level_next = level_reg;
        if (do_push && !do_pop) begin
            level_next = level_reg + LVL_W'(1);
        end else if (do_pop && !do_push) begin
            level_next = level_reg - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_reg <= '0;
        end else begin
            level_reg <= level_next;
        end
    end

endmodule

// File: rtl/icu_seq.sv
// icu_seq: clocked MC14500B-style sequencer over a DATA_W-bit result register.
// One instruction executes per accepted fetch handshake; results appear the
// following cycle. Stores go out through a valid/ready write port which
// back-pressures fetch while a store is pending.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/instr_ready  fetch handshake for instr_op, instr_addr, data_in
//   pc                       address of next instruction to fetch
//   wr_valid/wr_ready        write handshake for data_out
//   rr_out                   result register
//   jmp, rtn, flag_o, flag_f one-cycle pulses after executed JMP/RTN/NOPO/NOPF
//   stk_ovf, stk_unf         sticky return-stack overflow/underflow
//   stk_level                return-stack occupancy
module icu_seq
    import icu_seq_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             instr_valid,
    output logic                             instr_ready,
    input  instruction_t                     instr_op,
    input  logic [ADDR_W-1:0]                instr_addr,
    input  logic [DATA_W-1:0]                data_in,
    output logic [ADDR_W-1:0]                pc,
    output logic                             wr_valid,
    input  logic                             wr_ready,
    output logic [DATA_W-1:0]                data_out,
    output logic [DATA_W-1:0]                rr_out,
    output logic                             jmp,
    output logic                             rtn,
    output logic                             flag_o,
    output logic                             flag_f,
    output logic                             stk_ovf,
    output logic                             stk_unf,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stk_level
);

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [DATA_W-1:0] rr_reg, rr_next;
    logic [DATA_W-1:0] data_out_reg, data_out_next;
    logic              ien_reg, ien_next;
    logic              oen_reg, oen_next;
    logic              skip_reg, skip_next;
    logic              wr_valid_reg, wr_valid_next;
    logic              jmp_reg, jmp_next;
    logic              rtn_reg, rtn_next;
    logic              flag_o_reg, flag_o_next;
    logic              flag_f_reg, flag_f_next;
    logic              ovf_reg, ovf_next;
    logic              unf_reg, unf_next;

    logic              accept;
    logic              exec_ok;
    logic [DATA_W-1:0] m;
    logic [ADDR_W-1:0] pc_inc;
    logic              stk_push, stk_pop;
    logic              stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_dout;

    assign instr_ready = ~wr_valid_reg | wr_ready;
    assign accept      = instr_valid & instr_ready;
    // A pending skip swallows the next accepted instruction entirely.
    assign exec_ok     = accept & ~skip_reg;
    assign m           = ien_reg ? data_in : '0;
    assign pc_inc      = pc_reg + ADDR_W'(1);

    assign stk_push = exec_ok & (instr_op == JMP) & ~stk_full;
    assign stk_pop  = exec_ok & (instr_op == RTN) & ~stk_empty;

    icu_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty),
        .level (stk_level)
    );

    always_comb begin
        pc_next       = pc_reg;
        rr_next       = rr_reg;
        data_out_next = data_out_reg;
        ien_next      = ien_reg;
        oen_next      = oen_reg;
        skip_next     = skip_reg;
        wr_valid_next = wr_valid_reg;
        jmp_next      = 1'b0;
        rtn_next      = 1'b0;
        flag_o_next   = 1'b0;
        flag_f_next   = 1'b0;
        ovf_next      = ovf_reg;
        unf_next      = unf_reg;

        // Drain first so a store accepted in the same cycle can re-arm it.
        if (wr_valid_reg && wr_ready) begin
            wr_valid_next = 1'b0;
        end

        if (accept) begin
            pc_next = pc_inc;
            if (skip_reg) begin
                skip_next = 1'b0;
            end else begin
                case (instr_op)
                    LD:   rr_next = m;
                    LDC:  rr_next = ~m;
                    AND:  rr_next = rr_reg & m;
                    ANDC: rr_next = rr_reg & ~m;
                    OR:   rr_next = rr_reg | m;
                    ORC:  rr_next = rr_reg | ~m;
                    XNOR: rr_next = ~(rr_reg ^ m);
                    STO: begin
                        if (oen_reg) begin
                            data_out_next = rr_reg;
                            wr_valid_next = 1'b1;
                        end
                    end
                    STOC: begin
                        if (oen_reg) begin
                            data_out_next = ~rr_reg;
                            wr_valid_next = 1'b1;
                        end
                    end
                    IEN:  ien_next = data_in[0];
                    OEN:  oen_next = m[0];
                    JMP: begin
                        pc_next  = instr_addr;
                        jmp_next = 1'b1;
                        if (stk_full) begin
                            ovf_next = 1'b1;
                        end
                    end
                    RTN: begin
                        // The return site holds the JMP itself's successor
                        // slot convention: its first instruction is skipped.
                        rtn_next  = 1'b1;
                        skip_next = 1'b1;
                        if (stk_empty) begin
                            unf_next = 1'b1;
                        end else begin
                            pc_next = stk_dout;
                        end
                    end
                    SKZ:  skip_next   = (rr_reg == '0);
                    NOPO: flag_o_next = 1'b1;
                    NOPF: flag_f_next = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= '0;
            rr_reg       <= '0;
            data_out_reg <= '0;
            ien_reg      <= 1'b0;
            oen_reg      <= 1'b0;
            skip_reg     <= 1'b0;
            wr_valid_reg <= 1'b0;
            jmp_reg      <= 1'b0;
            rtn_reg      <= 1'b0;
            flag_o_reg   <= 1'b0;
            flag_f_reg   <= 1'b0;
            ovf_reg      <= 1'b0;
            unf_reg      <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            rr_reg       <= rr_next;
            data_out_reg <= data_out_next;
            ien_reg      <= ien_next;
            oen_reg      <= oen_next;
            skip_reg     <= skip_next;
            wr_valid_reg <= wr_valid_next;
            jmp_reg      <= jmp_next;
            rtn_reg      <= rtn_next;
            flag_o_reg   <= flag_o_next;
            flag_f_reg   <= flag_f_next;
            ovf_reg      <= ovf_next;
            unf_reg      <= unf_next;
        end
    end

    assign pc       = pc_reg;
    assign rr_out   = rr_reg;
    assign data_out = data_out_reg;
    assign wr_valid = wr_valid_reg;
    assign jmp      = jmp_reg;
    assign rtn      = rtn_reg;
    assign flag_o   = flag_o_reg;
    assign flag_f   = flag_f_reg;
    assign stk_ovf  = ovf_reg;
    assign stk_unf  = unf_reg;

endmodule

// File: tb/tb_icu_seq.sv
// Scoreboard bench for icu_seq (DATA_W=8, ADDR_W=8, STACK_DEPTH=2).
// The driver queues the hand-computed state expected after each instruction;
// a monitor pops and compares it one cycle after every accepted fetch, and
// compares data_out against a write queue on every write handshake.
module tb_icu_seq;
    import icu_seq_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    instruction_t instr_op = NOPO;
    logic [7:0]   instr_addr = '0;
    logic [7:0]   data_in = '0;
    logic [7:0]   pc;
    logic         wr_valid;
    logic         wr_ready = 1'b1;
    logic [7:0]   data_out;
    logic [7:0]   rr_out;
    logic         jmp, rtn, flag_o, flag_f, stk_ovf, stk_unf;
    logic [1:0]   stk_level;

    icu_seq #(.DATA_W(8), .ADDR_W(8), .STACK_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_addr  (instr_addr),
        .data_in     (data_in),
        .pc          (pc),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .data_out    (data_out),
        .rr_out      (rr_out),
        .jmp         (jmp),
        .rtn         (rtn),
        .flag_o      (flag_o),
        .flag_f      (flag_f),
        .stk_ovf     (stk_ovf),
        .stk_unf     (stk_unf),
        .stk_level   (stk_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] rr;
        logic       wv;
        logic [1:0] lvl;
        logic       ovf;
        logic       unf;
        logic [3:0] pl;   // {jmp, rtn, flag_o, flag_f}
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] wr_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_txn   = 0;

    function automatic exp_t E(logic [7:0] p, logic [7:0] r, logic w, logic [1:0] l,
                               logic o, logic u, logic [3:0] pl);
        exp_t e;
        e.pc = p; e.rr = r; e.wv = w; e.lvl = l; e.ovf = o; e.unf = u; e.pl = pl;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Monitor: inputs only change on negedge, so negedge+1 shows what the
    // next posedge will see; state is checked at posedge+1.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && wr_valid && wr_ready) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 32'(data_out), 32'hFFFF_FFFF);
                end else begin
                    chk("data_out", 32'(data_out), 32'(wr_q.pop_front()));
                end
            end
            if (!rst && instr_valid && instr_ready) begin
                @(posedge clk);
                #1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_accept", 32'(pc), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    n_txn++;
                    $display("[TB] txn %0d op=%s pc=%02h rr=%02h wv=%0b lvl=%0d",
                             n_txn, instr_op.name(), pc, rr_out, wr_valid, stk_level);
                    chk("pc", 32'(pc), 32'(e.pc));
                    chk("rr_out", 32'(rr_out), 32'(e.rr));
                    chk("wr_valid", 32'(wr_valid), 32'(e.wv));
                    chk("stk_level", 32'(stk_level), 32'(e.lvl));
                    chk("stk_ovf", 32'(stk_ovf), 32'(e.ovf));
                    chk("stk_unf", 32'(stk_unf), 32'(e.unf));
                    chk("pulses", 32'({jmp, rtn, flag_o, flag_f}), 32'(e.pl));
                end
            end
        end
    end

    task automatic exec(instruction_t op, logic [7:0] addr, logic [7:0] d, exp_t e);
        int n;
        @(negedge clk);
        instr_op    = op;
        instr_addr  = addr;
        data_in     = d;
        instr_valid = 1'b1;
        exp_q.push_back(e);
        #1;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 32'(instr_ready), 32'd1);
            void'(exp_q.pop_back());
        end
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_rr", 32'(rr_out), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_level", 32'(stk_level), 32'd0);
        chk("rst_flags", 32'({stk_ovf, stk_unf}), 32'd0);
        chk("rst_pulses", 32'({jmp, rtn, flag_o, flag_f}), 32'd0);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Masked loads and ANDC
        exec(IEN,  8'h00, 8'h01, E(8'h01, 8'h00, 0, 0, 0, 0, 4'b0000));
        exec(LD,   8'h00, 8'hA5, E(8'h02, 8'hA5, 0, 0, 0, 0, 4'b0000));
        exec(ANDC, 8'h00, 8'h0F, E(8'h03, 8'hA0, 0, 0, 0, 0, 4'b0000));
        exec(IEN,  8'h00, 8'h00, E(8'h04, 8'hA0, 0, 0, 0, 0, 4'b0000));
        exec(LD,   8'h00, 8'hFF, E(8'h05, 8'h00, 0, 0, 0, 0, 4'b0000));
        exec(OEN,  8'h00, 8'h01, E(8'h06, 8'h00, 0, 0, 0, 0, 4'b0000));
        exec(STO,  8'h00, 8'h00, E(8'h07, 8'h00, 0, 0, 0, 0, 4'b0000));
        exec(NOPO, 8'h00, 8'h00, E(8'h08, 8'h00, 0, 0, 0, 0, 4'b0010));
        exec(NOPF, 8'h00, 8'h00, E(8'h09, 8'h00, 0, 0, 0, 0, 4'b0001));
        exec(IEN,  8'h00, 8'h01, E(8'h0A, 8'h00, 0, 0, 0, 0, 4'b0000));
        exec(OEN,  8'h00, 8'h01, E(8'h0B, 8'h00, 0, 0, 0, 0, 4'b0000));
        exec(LD,   8'h00, 8'h3C, E(8'h0C, 8'h3C, 0, 0, 0, 0, 4'b0000));

        // Stalled store: fetch is blocked and pc frozen until wr_ready
        wr_ready = 1'b0;
        wr_q.push_back(8'h3C);
        exec(STO,  8'h00, 8'h00, E(8'h0D, 8'h3C, 1, 0, 0, 0, 4'b0000));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            instr_valid = 1'b1;
            instr_op    = LD;
            data_in     = 8'h55;
            #1;
            chk("stall_ready", 32'(instr_ready), 32'd0);
            chk("stall_wr_valid", 32'(wr_valid), 32'd1);
            chk("stall_data_out", 32'(data_out), 32'h3C);
            chk("stall_pc", 32'(pc), 32'h0D);
            chk("stall_rr", 32'(rr_out), 32'h3C);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        wr_ready    = 1'b1;
        @(negedge clk);
        #1;
        chk("wr_cleared", 32'(wr_valid), 32'd0);
        chk("post_stall_pc", 32'(pc), 32'h0D);

        wr_q.push_back(8'hC3);
        exec(STOC, 8'h00, 8'h00, E(8'h0E, 8'h3C, 1, 0, 0, 0, 4'b0000));

        // Skip on zero, then skip not taken
        exec(LD,   8'h00, 8'h00, E(8'h0F, 8'h00, 0, 0, 0, 0, 4'b0000));
        exec(SKZ,  8'h00, 8'h00, E(8'h10, 8'h00, 0, 0, 0, 0, 4'b0000));
        exec(LD,   8'h00, 8'h11, E(8'h11, 8'h00, 0, 0, 0, 0, 4'b0000));
        exec(LD,   8'h00, 8'h01, E(8'h12, 8'h01, 0, 0, 0, 0, 4'b0000));
        exec(SKZ,  8'h00, 8'h00, E(8'h13, 8'h01, 0, 0, 0, 0, 4'b0000));
        exec(LD,   8'h00, 8'h22, E(8'h14, 8'h22, 0, 0, 0, 0, 4'b0000));

        // JMP / RTN, return-site instruction skipped
        exec(JMP,  8'h40, 8'h00, E(8'h40, 8'h22, 0, 1, 0, 0, 4'b1000));
        exec(RTN,  8'h00, 8'h00, E(8'h15, 8'h22, 0, 0, 0, 0, 4'b0100));
        exec(LD,   8'h00, 8'h99, E(8'h16, 8'h22, 0, 0, 0, 0, 4'b0000));

        // Overflow and underflow on a 2-deep stack; skipped NOPs emit no pulse
        exec(JMP,  8'h50, 8'h00, E(8'h50, 8'h22, 0, 1, 0, 0, 4'b1000));
        exec(JMP,  8'h60, 8'h00, E(8'h60, 8'h22, 0, 2, 0, 0, 4'b1000));
        exec(JMP,  8'h70, 8'h00, E(8'h70, 8'h22, 0, 2, 1, 0, 4'b1000));
        exec(RTN,  8'h00, 8'h00, E(8'h51, 8'h22, 0, 1, 1, 0, 4'b0100));
        exec(NOPO, 8'h00, 8'h00, E(8'h52, 8'h22, 0, 1, 1, 0, 4'b0000));
        exec(RTN,  8'h00, 8'h00, E(8'h17, 8'h22, 0, 0, 1, 0, 4'b0100));
        exec(NOPO, 8'h00, 8'h00, E(8'h18, 8'h22, 0, 0, 1, 0, 4'b0000));
        exec(RTN,  8'h00, 8'h00, E(8'h19, 8'h22, 0, 0, 1, 1, 4'b0100));
        exec(NOPF, 8'h00, 8'h00, E(8'h1A, 8'h22, 0, 0, 1, 1, 4'b0000));

        // Reset during a stalled write drops it and clears sticky flags
        wr_ready = 1'b0;
        exec(STO,  8'h00, 8'h00, E(8'h1B, 8'h22, 1, 0, 1, 1, 4'b0000));
        do_reset();
        wr_ready = 1'b1;

        // ien cleared by reset; pc wraps from 0xFF to 0x00
        exec(LD,   8'h00, 8'h77, E(8'h01, 8'h00, 0, 0, 0, 0, 4'b0000));
        exec(JMP,  8'hFF, 8'h00, E(8'hFF, 8'h00, 0, 1, 0, 0, 4'b1000));
        exec(NOPO, 8'h00, 8'h00, E(8'h00, 8'h00, 0, 1, 0, 0, 4'b0010));

        repeat (3) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
